vip_ycbcr444_rgb888: RTL and testbench
======================================

// Module: vip_ycbcr444_rgb888
// PURPOSE
//  Inverse colour-space converter: YCbCr444 (full-range, Cb/Cr offset 128) back to RGB888.
//  Sits after YCbCr-domain processing in the VIP chain, feeding display/BMP-writer paths.
//  Fixed 3-clock pipeline; frame vsync/href/clken are delayed to stay aligned with the pixels.
//  Out-of-range results are saturated to 0..255.
// PARAMETERS
//  CLIP_CNT_W  20  width of per-frame clipped-pixel counter (used only with the counter macro)
// PORTS
//  clk               in   1   pixel clock, all logic on posedge
//  rst               in   1   synchronous, active-high reset
//  per_frame_vsync   in   1   input vsync
//  per_frame_href    in   1   input href (line valid)
//  per_frame_clken   in   1   input pixel enable
//  per_img_Y         in   8   luma
//  per_img_Cb        in   8   blue chroma, offset 128
//  per_img_Cr        in   8   red chroma, offset 128
//  post_frame_vsync  out  1   vsync delayed 3 clk
//  post_frame_href   out  1   href delayed 3 clk
//  post_frame_clken  out  1   clken delayed 3 clk
//  post_img_red      out  8   R result
//  post_img_green    out  8   G result
//  post_img_blue     out  8   B result
//  clip_cnt          out  CLIP_CNT_W  clipped pixels of last frame (macro only)
// BEHAVIOUR
//  Math (x256 fixed point, cb=Cb-128, cr=Cr-128 signed 9b, all sums signed 20b):
//   R = (256*Y + 359*cr          + 128) >>> 8
//   G = (256*Y -  88*cb - 183*cr + 128) >>> 8
//   B = (256*Y + 454*cb          + 128) >>> 8   (arithmetic shift, +128 = round half up)
//  Stage 1: register 256*Y, 359*cr, 88*cb, 183*cr, 454*cb (signed).
//  Stage 2: register the three signed sums incl. +128.
//  Stage 3: shift; result <0 -> 0, >255 -> 255, else low 8 bits; register 8b + per-channel clip flag.
//  Pipeline advances every clk regardless of clken; latency exactly 3 clk.
//  vsync/href/clken: 3-deep shift registers; post_* = bit [2].
//  post_img_* = stage-3 value when post_frame_href=1, else 8'd0.
//  Reset: every pipeline/sync reg -> 0; all outputs 0 on the cycle after rst sampled high.
//  Reset mid-frame: in-flight pixels discarded, no partial output; resumes 3 clk after rst release.
//  Back-to-back pixels: one result per clk, no bubbles, no stall input.
// CONFIGURATION
//  `YCBCR2RGB_CLIP_CNT_EN defined:
//   - acc counts stage-3 pixels with delayed href&clken=1 and any channel clipped; saturates at all-ones.
//   - On delayed-vsync 1->0 edge (frame end): clip_cnt <= acc; acc <= (this cycle's pixel clipped ? 1 : 0).
//   - rst clears acc and clip_cnt.
//  Undefined: no counter logic; clip_cnt tied to 0.
// TESTING
//  Y=128,Cb=128,Cr=128 -> RGB=(128,128,128) exactly 3 clk later.
//  Y=76,Cb=85,Cr=255 -> (254,0,0); G path hits -1 pre-round, check floor/round gives 0.
//  Y=0,Cb=0,Cr=0 -> (0,136,0) R/B clamp low; Y=255,Cb=128,Cr=255 -> R=255 clamp high.
//  Continuous stream with href toggling -> post_img_* 0 exactly where post_frame_href=0; sync delay = 3.
//  rst pulsed mid-line -> outputs/sync 0 next clk; first valid pixel 3 clk after release.
//  Macro on: frame of 10 pixels, 3 clipping -> clip_cnt=3 after vsync falls; acc saturation at 2^CLIP_CNT_W-1.

Source files
------------

// File: rtl/vip_ycbcr444_rgb888.sv
// YCbCr444 (full range, chroma offset 128) to RGB888, fixed 3-clock pipeline with saturation.
// Optional per-frame clipped-pixel counter enabled by defining YCBCR2RGB_CLIP_CNT_EN.
module vip_ycbcr444_rgb888 #(
  parameter int CLIP_CNT_W = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  per_frame_vsync,
  input  logic                  per_frame_href,
  input  logic                  per_frame_clken,
  input  logic [7:0]            per_img_Y,
  input  logic [7:0]            per_img_Cb,
  input  logic [7:0]            per_img_Cr,
  output logic                  post_frame_vsync,
  output logic                  post_frame_href,
  output logic                  post_frame_clken,
  output logic [7:0]            post_img_red,
  output logic [7:0]            post_img_green,
  output logic [7:0]            post_img_blue,
  output logic [CLIP_CNT_W-1:0] clip_cnt
);

  logic signed [8:0]  w_cb, w_cr;
  logic signed [19:0] w_cb_x, w_cr_x, w_y256;

  assign w_cb   = $signed({1'b0, per_img_Cb}) - 9'sd128;
  assign w_cr   = $signed({1'b0, per_img_Cr}) - 9'sd128;
  assign w_cb_x = 20'(w_cb);
  assign w_cr_x = 20'(w_cr);
  assign w_y256 = $signed({4'b0, per_img_Y, 8'b0});

  // stage 1: partial products
  logic signed [19:0] r_y256, r_cr359, r_cb88, r_cr183, r_cb454;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y256  <= '0;
      r_cr359 <= '0;
      r_cb88  <= '0;
      r_cr183 <= '0;
      r_cb454 <= '0;
    end else begin
      r_y256  <= w_y256;
      r_cr359 <= w_cr_x * 20'sd359;
      r_cb88  <= w_cb_x * 20'sd88;
      r_cr183 <= w_cr_x * 20'sd183;
      r_cb454 <= w_cb_x * 20'sd454;
    end
  end

  // stage 2: rounded sums, channel order {B, G, R}
  logic [2:0][19:0] r_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
    end else begin
      r_sum[0] <= r_y256 + r_cr359 + 20'sd128;
      r_sum[1] <= r_y256 - r_cb88 - r_cr183 + 20'sd128;
      r_sum[2] <= r_y256 + r_cb454 + 20'sd128;
    end
  end

  // stage 3: floor shift then clamp to 0..255
  logic [2:0][7:0] w_pix;
`ifdef YCBCR2RGB_CLIP_CNT_EN
  logic [2:0]      w_clip;
`endif

  always_comb begin
    logic signed [19:0] sh;
    w_pix = '0;
    sh    = '0;
`ifdef YCBCR2RGB_CLIP_CNT_EN
    w_clip = '0;
`endif
    for (int c = 0; c < 3; c++) begin
      sh = $signed(r_sum[c]) >>> 8;
      if (sh < 0)            w_pix[c] = 8'd0;
      else if (sh > 20'sd255) w_pix[c] = 8'd255;
      else                   w_pix[c] = sh[7:0];
`ifdef YCBCR2RGB_CLIP_CNT_EN
      w_clip[c] = (sh < 0) || (sh > 20'sd255);
`endif
    end
  end

  logic [2:0][7:0] r_pix;
  logic [2:0]      r_vs_pipe, r_hr_pipe, r_ce_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix     <= '0;
      r_vs_pipe <= '0;
      r_hr_pipe <= '0;
      r_ce_pipe <= '0;
    end else begin
      r_pix     <= w_pix;
      r_vs_pipe <= {r_vs_pipe[1:0], per_frame_vsync};
      r_hr_pipe <= {r_hr_pipe[1:0], per_frame_href};
      r_ce_pipe <= {r_ce_pipe[1:0], per_frame_clken};
    end
  end

  assign post_frame_vsync = r_vs_pipe[2];
  assign post_frame_href  = r_hr_pipe[2];
  assign post_frame_clken = r_ce_pipe[2];
  assign post_img_red     = r_hr_pipe[2] ? r_pix[0] : 8'd0;
  assign post_img_green   = r_hr_pipe[2] ? r_pix[1] : 8'd0;
  assign post_img_blue    = r_hr_pipe[2] ? r_pix[2] : 8'd0;

`ifdef YCBCR2RGB_CLIP_CNT_EN
  logic                  r_clip_any, r_vs_d;
  logic [CLIP_CNT_W-1:0] r_acc, r_clip_cnt;
  logic                  w_pix_clip, w_frame_end;

  assign w_pix_clip  = r_hr_pipe[2] & r_ce_pipe[2] & r_clip_any;
  assign w_frame_end = r_vs_d & ~r_vs_pipe[2];

  // the pixel that lands on the vsync falling edge belongs to the next frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clip_any <= 1'b0;
      r_vs_d     <= 1'b0;
      r_acc      <= '0;
      r_clip_cnt <= '0;
    end else begin
      r_clip_any <= |w_clip;
      r_vs_d     <= r_vs_pipe[2];
      if (w_frame_end) begin
        r_clip_cnt <= r_acc;
        r_acc      <= w_pix_clip ? CLIP_CNT_W'(1) : '0;
      end else if (w_pix_clip && !(&r_acc)) begin
        r_acc <= r_acc + 1'b1;
      end
    end
  end

  assign clip_cnt = r_clip_cnt;
`else
  assign clip_cnt = '0;
`endif

endmodule

// File: tb/tb_vip_ycbcr444_rgb888.sv
// Bench for vip_ycbcr444_rgb888: directed colour vectors plus a random stream checked against
// an arithmetic reference model; models the clip counter when YCBCR2RGB_CLIP_CNT_EN is defined.
module tb_vip_ycbcr444_rgb888;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vs = 1'b0, hr = 1'b0, ce = 1'b0;
  logic [7:0]    y = '0, cb = '0, cr = '0;
  logic          o_vs, o_hr, o_ce;
  logic [7:0]    o_r, o_g, o_b;
  logic [CW-1:0] o_cnt;

  always #5 clk = ~clk;

  vip_ycbcr444_rgb888 #(.CLIP_CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce),
    .per_img_Y(y), .per_img_Cb(cb), .per_img_Cr(cr),
    .post_frame_vsync(o_vs), .post_frame_href(o_hr), .post_frame_clken(o_ce),
    .post_img_red(o_r), .post_img_green(o_g), .post_img_blue(o_b),
    .clip_cnt(o_cnt)
  );

  typedef struct {
    bit       rst, vs, hr, ce;
    bit [7:0] y, cb, cr;
    bit       has_exp;
    int       er, eg, eb;
  } stim_t;

  stim_t hist[$];
  int    checks = 0, failures = 0;
  int    m_acc = 0, m_cnt = 0;
  bit    m_vsp = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d (cycle %0d)", tag, act, exp, hist.size());
    end
  endtask

  // integer floor-divide by 256 with round-half-up, then saturate
  function automatic int conv(input int num, output bit clipped);
    int q;
    q = (num + 128) >>> 8;
    clipped = (q < 0) || (q > 255);
    return (q < 0) ? 0 : (q > 255) ? 255 : q;
  endfunction

  task automatic step(input stim_t s);
    int  k, r, g, b;
    bit  live, evs, ehr, ece, epc, c0, c1, c2;
    stim_t p;
    @(negedge clk);
    k = hist.size();
    evs = 0; ehr = 0; ece = 0; epc = 0; r = 0; g = 0; b = 0;
    live = (k >= 3);
    if (live) for (int j = 1; j <= 3; j++) if (hist[k-j].rst) live = 0;
    if (live) begin
      int cbs, crs;
      p = hist[k-3];
      cbs = int'(p.cb) - 128;
      crs = int'(p.cr) - 128;
      r = conv(256*p.y + 359*crs, c0);
      g = conv(256*p.y - 88*cbs - 183*crs, c1);
      b = conv(256*p.y + 454*cbs, c2);
      evs = p.vs; ehr = p.hr; ece = p.ce;
      epc = p.hr & p.ce & (c0 | c1 | c2);
      if (!p.hr) begin r = 0; g = 0; b = 0; end
    end
    if (k > 0) begin
      chk("vsync", o_vs, evs);
      chk("href",  o_hr, ehr);
      chk("clken", o_ce, ece);
      chk("red",   o_r, r);
      chk("green", o_g, g);
      chk("blue",  o_b, b);
      if (live && p.has_exp) begin
        chk("dir_red",   o_r, p.er);
        chk("dir_green", o_g, p.eg);
        chk("dir_blue",  o_b, p.eb);
      end
`ifdef YCBCR2RGB_CLIP_CNT_EN
      chk("clip_cnt", o_cnt, m_cnt);
`else
      chk("clip_cnt", o_cnt, 0);
`endif
    end
    rst = s.rst; vs = s.vs; hr = s.hr; ce = s.ce; y = s.y; cb = s.cb; cr = s.cr;
    hist.push_back(s);
    if (s.rst) begin
      m_acc = 0; m_cnt = 0; m_vsp = 0;
    end else begin
      if (m_vsp && !evs) begin
        m_cnt = m_acc;
        m_acc = epc ? 1 : 0;
      end else if (epc && m_acc != (1 << CW) - 1) begin
        m_acc++;
      end
      m_vsp = evs;
    end
  endtask

  task automatic px(input bit r_, v_, h_, c_, input int y_, cb_, cr_);
    stim_t s;
    s = '{r_, v_, h_, c_, 8'(y_), 8'(cb_), 8'(cr_), 0, 0, 0, 0};
    step(s);
  endtask

  task automatic dpx(input int y_, cb_, cr_, er_, eg_, eb_);
    stim_t s;
    s = '{0, 1, 1, 1, 8'(y_), 8'(cb_), 8'(cr_), 1, er_, eg_, eb_};
    step(s);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) px(1, 0, 0, 0, 0, 0, 0);
    dpx(128, 128, 128, 128, 128, 128);
    dpx(76, 85, 255, 254, 0, 0);
    dpx(0, 0, 0, 0, 136, 0);
    dpx(255, 128, 255, 255, 164, 255);
    for (int i = 0; i < 5; i++) px(0, 0, 0, 0, 0, 0, 0);
    // frame of 10 pixels, 3 of them clip
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 1) px(0, 1, 1, 1, 0, 0, 0);
      else            px(0, 1, 1, 1, 128, 128, 128);
    end
    for (int i = 0; i < 6; i++) px(0, 0, 0, 0, 0, 0, 0);
    // mid-line reset pulse
    for (int i = 0; i < 4; i++) px(0, 1, 1, 1, $urandom_range(0, 255), 128, 128);
    px(1, 1, 1, 1, 10, 20, 30);
    for (int i = 0; i < 6; i++) px(0, 1, 1, 1, $urandom_range(0, 255), $urandom_range(0, 255), 200);
    // random stream with frames long enough to saturate the counter
    for (int i = 0; i < 900; i++) begin
      int fp;
      bit rr;
      fp = i % 70;
      rr = (i % 250 == 120) || (i % 250 == 121);
      px(rr, fp < 60, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
         $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    end
    for (int i = 0; i < 6; i++) px(0, 0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
